irq_ctrl_apb_slave: RTL

IRQ_CTRL_APB_SLAVE -- requirements
Module: irq_ctrl_apb_slave

---
 rtl/irq_ctrl_pkg.sv | 39 +++
 rtl/irq_prio_arbiter.sv | 58 +++++
 rtl/irq_ctrl_apb_slave.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_pkg
// Purpose  : Shared definitions for the APB interrupt controller. It holds the
//            register word addresses, the source count, the priority width,
//            the APB responder state encoding and the transfer-error decode.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    localparam int NUM_IRQ = 4;
    localparam int PRIO_W  = 3;
    localparam int ID_W    = 2;

    localparam logic [31:0] ADDR_CTRL    = 32'd0;
    localparam logic [31:0] ADDR_PENDING = 32'd1;
    localparam logic [31:0] ADDR_STATUS  = 32'd2;
    localparam logic [31:0] ADDR_MASK    = 32'd3;
    localparam logic [31:0] ADDR_PTH     = 32'd4;
    localparam logic [31:0] ADDR_IRQ0    = 32'd5;
    localparam logic [31:0] ADDR_IRQ1    = 32'd6;
    localparam logic [31:0] ADDR_IRQ2    = 32'd7;
    localparam logic [31:0] ADDR_IRQ3    = 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // A transfer fails when it targets an address beyond the register map,
    // or when it tries to write the read-only PENDING view.
    function automatic logic addr_error(input logic [31:0] addr, input logic write);
        return (addr > ADDR_IRQ3) || (write && (addr == ADDR_PENDING));
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_arbiter
// Purpose  : Purely combinational eligibility and priority selection. A
//            source is eligible when it is pending, unmasked, globally enabled
//            and its priority is strictly above the threshold. The eligible
//            source with the largest priority wins; ties go to the lowest
//            index.
// Ports    : status, mask    - per-source pending and enable bits
//            enable          - global interrupt enable
//            pth             - priority threshold
//            prio            - per-source priority values
//            any_eligible    - at least one source is eligible
//            winner_id       - index of the winning source (0 if none)
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_arbiter
    import irq_ctrl_pkg::*;
(
    input  logic [NUM_IRQ-1:0]             status,
    input  logic [NUM_IRQ-1:0]             mask,
    input  logic                           enable,
    input  logic [PRIO_W-1:0]              pth,
    input  logic [NUM_IRQ-1:0][PRIO_W-1:0] prio,
    output logic                           any_eligible,
    output logic [ID_W-1:0]                winner_id
);

    logic [NUM_IRQ-1:0] w_elig;
    logic               w_found;
    logic [PRIO_W-1:0]  w_best_prio;

    // Strict compare means priority 0 can never beat the minimum threshold.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_elig
            assign w_elig[gi] = status[gi] & mask[gi] & enable & (prio[gi] > pth);
        end
    endgenerate

    // Ascending scan with a strict '>' keeps the lowest index on a tie.
    always_comb begin
        w_found     = 1'b0;
        w_best_prio = '0;
        winner_id   = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_elig[i] && (!w_found || (prio[i] > w_best_prio))) begin
                w_found     = 1'b1;
                w_best_prio = prio[i];
                winner_id   = ID_W'(i);
            end
        end
    end

    assign any_eligible = |w_elig;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl_apb_slave.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_apb_slave
// Purpose  : Four-source priority interrupt controller with an APB register
//            interface. Requests latch into STATUS every cycle, are filtered
//            by MASK / global enable / threshold, and the registered winner
//            drives interrupt_o and irq_id_o.
// Ports    : pclk_i, rst_n_i         - clock, async active-low reset
//            psel_i, penable_i,
//            pwrite_i, paddr_i,
//            pwdata_i                - APB request
//            prdata_o, pready_o,
//            pslverr_o               - APB response
//            irq_trigger_i           - per-source requests (active high)
//            interrupt_o, irq_id_o   - interrupt line and winning index
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl_apb_slave
    import irq_ctrl_pkg::*;
(
    input  logic               pclk_i,
    input  logic               rst_n_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [31:0]        paddr_i,
    input  logic [31:0]        pwdata_i,
    input  logic [NUM_IRQ-1:0] irq_trigger_i,
    output logic [31:0]        prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    output logic               interrupt_o,
    output logic [ID_W-1:0]    irq_id_o
);

    apb_state_e                     r_state;
    apb_state_e                     w_state_next;

    logic                           r_ctrl_en;
    logic [NUM_IRQ-1:0]             r_status;
    logic [NUM_IRQ-1:0]             r_mask;
    logic [PRIO_W-1:0]              r_pth;
    logic [NUM_IRQ-1:0][PRIO_W-1:0] r_prio;
    logic [31:0]                    r_prdata;
    logic                           r_interrupt;
    logic [ID_W-1:0]                r_irq_id;

    logic                           w_err;
    logic                           w_wr_commit;
    logic [NUM_IRQ-1:0]             w_status_clr;
    logic [31:0]                    w_rdata;
    logic                           w_any;
    logic [ID_W-1:0]                w_winner;
    logic                           w_unused_wdata;

    assign w_unused_wdata = &pwdata_i[31:NUM_IRQ];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An access phase that did not follow a setup phase is left in IDLE, so
    // it never produces pready_o and never commits.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (psel_i && !penable_i) w_state_next = ST_SETUP;
            ST_SETUP:  w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = (psel_i && !penable_i) ? ST_SETUP : ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    assign w_err       = addr_error(paddr_i, pwrite_i);
    assign w_wr_commit = (r_state == ST_ACCESS) && psel_i && penable_i && pwrite_i && !w_err;
    assign pready_o    = (r_state == ST_ACCESS);
    assign pslverr_o   = (r_state == ST_ACCESS) && w_err;

    // ---------------------------------------------------------- read path
    always_comb begin
        w_rdata = '0;
        case (paddr_i)
            ADDR_CTRL:    w_rdata[0]            = r_ctrl_en;
            ADDR_PENDING: w_rdata[NUM_IRQ-1:0]  = r_status & r_mask;
            ADDR_STATUS:  w_rdata[NUM_IRQ-1:0]  = r_status;
            ADDR_MASK:    w_rdata[NUM_IRQ-1:0]  = r_mask;
            ADDR_PTH:     w_rdata[PRIO_W-1:0]   = r_pth;
            ADDR_IRQ0:    w_rdata[PRIO_W-1:0]   = r_prio[0];
            ADDR_IRQ1:    w_rdata[PRIO_W-1:0]   = r_prio[1];
            ADDR_IRQ2:    w_rdata[PRIO_W-1:0]   = r_prio[2];
            ADDR_IRQ3:    w_rdata[PRIO_W-1:0]   = r_prio[3];
            default:      w_rdata               = '0;
        endcase
    end

    // Read data is sampled on entry to SETUP so it is stable for all of ACCESS.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_prdata <= '0;
        end else if (w_state_next == ST_SETUP) begin
            r_prdata <= w_err ? 32'd0 : w_rdata;
        end
    end

    assign prdata_o = r_prdata;

    // ---------------------------------------------------------- registers
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ctrl_en <= 1'b1;
            r_mask    <= '0;
            r_pth     <= '0;
            r_prio    <= '0;
        end else if (w_wr_commit) begin
            if (paddr_i == ADDR_CTRL) r_ctrl_en <= pwdata_i[0];
            if (paddr_i == ADDR_MASK) r_mask    <= pwdata_i[NUM_IRQ-1:0];
            if (paddr_i == ADDR_PTH)  r_pth     <= pwdata_i[PRIO_W-1:0];
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (paddr_i == (ADDR_IRQ0 + 32'(i))) r_prio[i] <= pwdata_i[PRIO_W-1:0];
            end
        end
    end

    assign w_status_clr = (w_wr_commit && (paddr_i == ADDR_STATUS)) ? pwdata_i[NUM_IRQ-1:0] : '0;

    // OR-ing the request after the clear lets a new request win a same-cycle W1C.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_status_clr) | irq_trigger_i;
        end
    end

    // ------------------------------------------------------- arbitration
    irq_prio_arbiter u_arbiter (
        .status       (r_status),
        .mask         (r_mask),
        .enable       (r_ctrl_en),
        .pth          (r_pth),
        .prio         (r_prio),
        .any_eligible (w_any),
        .winner_id    (w_winner)
    );

    // irq_id_o keeps the last winner while no source is eligible.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_interrupt <= 1'b0;
            r_irq_id    <= '0;
        end else begin
            r_interrupt <= w_any;
            if (w_any) r_irq_id <= w_winner;
        end
    end

    assign interrupt_o = r_interrupt;
    assign irq_id_o    = r_irq_id;

endmodule
`default_nettype wire
